maxpool_scheduler: RTL and testbench
====================================

Name: maxpool_scheduler

Overview:
- Sequencing controller for the 2x2/stride-2 max-pool stage of the CNN pipeline.
- Walks all D channels of an H x W feature map held in a word-addressed feature buffer, one pooling window at a time.
  - Issues 4 buffer reads per window and reduces them with a signed max comparator.
  - Writes one result word per window to the pooled-output buffer.
- Driven by the layer sequencer through the start_flag/over_flag handshake, replacing the fully parallel per-channel pooling datapath with a serial, memory-based one.

Parameters:
- DATA_WIDTH, 16, width of one signed fixed-point feature word
- D, 6, number of channels
- H, 28, input map height; must be >= 2
- W, 28, input map width; must be >= 2
- ADDR_WIDTH, 16, width of read and write address buses; must hold D*H*W-1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start_flag  input  1  start one full layer pass; sampled only in IDLE
- over_flag  output  1  layer pass complete; level signal
- busy  output  1  high from the cycle after start is accepted until the last write completes
- rd_en  output  1  feature-buffer read strobe
- rd_addr  output  ADDR_WIDTH  feature-buffer read address
- rd_data  input  DATA_WIDTH  read data; valid exactly 1 cycle after rd_en
- wr_en  output  1  output-buffer write strobe
- wr_addr  output  ADDR_WIDTH  output-buffer write address
- wr_data  output  DATA_WIDTH  pooled result
- wr_ready  input  1  output buffer accepts the write this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; all counters 0.
  - over_flag, busy, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0.
- Addressing:
  - Input element (c,r,x) is at c*H*W + r*W + x.
  - Output element (c,i,j) is at c*HO*WO + i*WO + j, where HO = H/2 and WO = W/2 (floor).
  - For odd H or W, the last row or column is never read.
- Iteration order: channel outermost, then output row i, then output column j innermost.
- Read order within a window: (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1).
- States:
  - IDLE: start_flag=1 clears over_flag, sets busy, clears counters, goes to RD0. start_flag=0 stays in IDLE.
  - RD0..RD3: one read per cycle, rd_en=1 with that element's address.
  - WAIT: rd_en=0. The 4th read datum arrives and the max is finalized.
  - WRITE: wr_en=1 with wr_addr and wr_data held stable. The write completes in a cycle with wr_ready=1.
    - Not the last window: advance counters and go to RD0.
    - Last window: go to DONE.
  - DONE: busy=0, over_flag=1; go to IDLE.
- Max datapath:
  - The datum arriving in the cycle after RD0 loads the accumulator.
  - Each of the next 3 data updates acc = max(acc, rd_data), signed two's-complement compare.
  - Ties keep acc. No width growth.
- Latency with wr_ready held at 1:
  - 6 cycles per window.
  - Total = 6*D*HO*WO + 1 cycles from accepting start to over_flag=1.
- Back-pressure: wr_ready=0 holds WRITE indefinitely with all outputs stable. Reads never advance during a stall.
- over_flag rises in the cycle DONE is reached and stays 1 until the next accepted start_flag.
- start_flag while busy is ignored and does not restart or corrupt the pass.
- Reset mid-pass aborts immediately. No write is issued after reset deasserts unless a new start is accepted.
- Counters wrap only at layer end: j to 0 at WO, i to 0 at HO, c increments. The last window is c=D-1, i=HO-1, j=WO-1.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: wr_data = (acc < 0) ? 0 : acc (fused ReLU); timing unchanged.
- Undefined: wr_data = acc, signed values pass through unchanged.

Test Plan:
- D=1, H=W=2, buffer {3,-7,9,2}, wr_ready=1 -> exactly one write, wr_addr=0, wr_data=9. over_flag=1 exactly 7 cycles after start is accepted.
- D=2, H=W=4, buffer[k]=k -> 8 writes with addresses 0..7 in order. Data are 5,7,13,15,21,23,29,31. Reads follow the row-major 2x2 order given above.
- All-negative window {-5,-3,-8,-3} -> wr_data=-3 without MAXPOOL_RELU_EN; wr_data=0 with it.
- wr_ready=0 for 10 cycles during the 2nd write -> wr_en, wr_addr and wr_data held constant with rd_en=0. The pass finishes 10 cycles later than the unstalled run.
- start_flag pulsed again mid-pass, then rst=0 mid-pass -> the second start has no effect. Reset clears busy, over_flag, rd_en and wr_en at once. A fresh start after reset completes a full, correct pass.
- H=W=5, D=1 -> 4 writes only; row 4 and column 4 are never read.

Source files
------------

// File: rtl/maxpool_scheduler.sv
// Serial 2x2/stride-2 max-pool sequencer: walks a D x H x W feature buffer one window at a time.
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int D          = 6,
   parameter int H          = 28,
   parameter int W          = 28,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_flag,
   output logic                  over_flag,
   output logic                  busy,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ready
);

   localparam int HO = H / 2;
   localparam int WO = W / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam int IW = (HO > 1) ? $clog2(HO) : 1;
   localparam int JW = (WO > 1) ? $clog2(WO) : 1;

   localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO_A = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] W_A   = ADDR_WIDTH'(W);
   localparam logic [ADDR_WIDTH-1:0] W2_A  = ADDR_WIDTH'(2 * W);
   localparam logic [ADDR_WIDTH-1:0] HW_A  = ADDR_WIDTH'(H * W);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]                c_cnt;
   logic [IW-1:0]                i_cnt;
   logic [JW-1:0]                j_cnt;
   logic [ADDR_WIDTH-1:0]        chan_base;
   logic [ADDR_WIDTH-1:0]        row_base;
   logic [ADDR_WIDTH-1:0]        in_base;
   logic [ADDR_WIDTH-1:0]        out_addr;
   logic signed [DATA_WIDTH-1:0] acc;
   logic signed [DATA_WIDTH-1:0] rd_s;
   logic signed [DATA_WIDTH-1:0] pool_val;
   logic                         last_win;
   logic                         write_done;
   logic                         start_ok;

   // Write handshake: a transfer happens in a cycle where wr_en and wr_ready are both 1;
   // while wr_en=1 and wr_ready=0, wr_addr and wr_data hold and no reads are issued.

   assign rd_s       = $signed(rd_data);
   assign last_win   = (c_cnt == CW'(D - 1)) && (i_cnt == IW'(HO - 1)) && (j_cnt == JW'(WO - 1));
   assign write_done = (state == S_WRITE) && wr_ready;
   assign start_ok   = (state == S_IDLE) && start_flag;

`ifdef MAXPOOL_RELU_EN
   assign pool_val = acc[DATA_WIDTH-1] ? '0 : acc;
`else
   assign pool_val = acc;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_flag) state_nxt = S_RD0;
         S_RD0:   state_nxt = S_RD1;
         S_RD1:   state_nxt = S_RD2;
         S_RD2:   state_nxt = S_RD3;
         S_RD3:   state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_WRITE;
         S_WRITE: if (wr_ready) state_nxt = last_win ? S_DONE : S_RD0;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      case (state)
         S_RD0: begin rd_en = 1'b1; rd_addr = in_base;               end
         S_RD1: begin rd_en = 1'b1; rd_addr = in_base + ONE_A;       end
         S_RD2: begin rd_en = 1'b1; rd_addr = in_base + W_A;         end
         S_RD3: begin rd_en = 1'b1; rd_addr = in_base + W_A + ONE_A; end
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = out_addr;
            wr_data = pool_val;
         end
         default: ;
      endcase
   end

   // Window bases advance incrementally; row/channel jumps skip any unread odd row or column.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= 1'b0;
         over_flag <= 1'b0;
         c_cnt     <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         chan_base <= '0;
         row_base  <= '0;
         in_base   <= '0;
         out_addr  <= '0;
      end else if (start_ok) begin
         busy      <= 1'b1;
         over_flag <= 1'b0;
         c_cnt     <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         chan_base <= '0;
         row_base  <= '0;
         in_base   <= '0;
         out_addr  <= '0;
      end else if (write_done) begin
         if (last_win) begin
            busy      <= 1'b0;
            over_flag <= 1'b1;
         end else begin
            out_addr <= out_addr + ONE_A;
            if (j_cnt == JW'(WO - 1)) begin
               j_cnt <= '0;
               if (i_cnt == IW'(HO - 1)) begin
                  i_cnt     <= '0;
                  c_cnt     <= c_cnt + CW'(1);
                  chan_base <= chan_base + HW_A;
                  row_base  <= chan_base + HW_A;
                  in_base   <= chan_base + HW_A;
               end else begin
                  i_cnt    <= i_cnt + IW'(1);
                  row_base <= row_base + W2_A;
                  in_base  <= row_base + W2_A;
               end
            end else begin
               j_cnt   <= j_cnt + JW'(1);
               in_base <= in_base + TWO_A;
            end
         end
      end
   end

   // Data lands one cycle after each read, so RD1 sees the first element and WAIT the last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else begin
         case (state)
            S_RD1:                 acc <= rd_s;
            S_RD2, S_RD3, S_WAIT:  if (rd_s > acc) acc <= rd_s;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Bench for maxpool_scheduler: three small geometries, table-driven windows, scoreboarded writes.
module tb_maxpool_scheduler;

   logic              clk;
   logic              rst;
   logic [2:0]        start;
   logic [2:0]        over_flag;
   logic [2:0]        busy;
   logic [2:0]        rd_en;
   logic [2:0]        wr_en;
   logic [2:0]        wr_ready;
   logic [15:0]       rd_addr [3];
   logic [15:0]       rd_data [3];
   logic [15:0]       wr_addr [3];
   logic [15:0]       wr_data [3];

   logic signed [15:0] mem0 [4];
   logic signed [15:0] mem1 [32];
   logic signed [15:0] mem2 [25];

   typedef struct packed {
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic signed [15:0] c;
      logic signed [15:0] d;
      logic signed [15:0] exp_max;
   } vec_t;

   vec_t vecs [8];

   logic [33:0] exp_q [$];
   logic [15:0] rd_q [$];
   logic        chk_rd;
   int          checks;
   int          errors;
   int          rd_cnt2;
   int          bad_rd2;

   maxpool_scheduler #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .ADDR_WIDTH(16)) u_a (
      .clk(clk), .rst(rst), .start_flag(start[0]), .over_flag(over_flag[0]), .busy(busy[0]),
      .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ready(wr_ready[0])
   );

   maxpool_scheduler #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .ADDR_WIDTH(16)) u_b (
      .clk(clk), .rst(rst), .start_flag(start[1]), .over_flag(over_flag[1]), .busy(busy[1]),
      .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
      .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ready(wr_ready[1])
   );

   maxpool_scheduler #(.DATA_WIDTH(16), .D(1), .H(5), .W(5), .ADDR_WIDTH(16)) u_c (
      .clk(clk), .rst(rst), .start_flag(start[2]), .over_flag(over_flag[2]), .busy(busy[2]),
      .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
      .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .wr_ready(wr_ready[2])
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // feature-buffer models: one-cycle read latency
   always_ff @(posedge clk) begin
      if (rd_en[0]) rd_data[0] <= mem0[rd_addr[0][1:0]];
      if (rd_en[1]) rd_data[1] <= mem1[rd_addr[1][4:0]];
      if (rd_en[2]) rd_data[2] <= (rd_addr[2] < 16'd25) ? mem2[rd_addr[2][4:0]] : 16'h0;
   end

   function automatic logic signed [15:0] max4(input logic signed [15:0] a, b, c, d);
      logic signed [15:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic logic signed [15:0] out_of(input logic signed [15:0] x);
`ifdef MAXPOOL_RELU_EN
      return (x < 0) ? 16'sd0 : x;
`else
      return x;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // scoreboard / monitors, sampled 2 time units after the falling edge
   always @(negedge clk) begin
      #2;
      if (rst) begin
         for (int u = 0; u < 3; u++) begin
            if (wr_en[u] && wr_ready[u]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write dut=%0d addr=%0d data=%0h expected=none", u, wr_addr[u], wr_data[u]);
               end else begin
                  check("write", {2'(u), wr_addr[u], wr_data[u]}, exp_q.pop_front());
               end
            end
         end
         if (chk_rd && rd_en[1]) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read addr=%0d expected=none", rd_addr[1]);
            end else begin
               check("rd_order", rd_addr[1], rd_q.pop_front());
            end
         end
         if (rd_en[2]) begin
            rd_cnt2++;
            if ((int'(rd_addr[2]) % 5 == 4) || (int'(rd_addr[2]) / 5 == 4)) bad_rd2++;
         end
      end
   end

   // driver: one full pass on dut u, optional wr_ready stall during write number stall_at
   task automatic run_pass(input int u, input int stall_at, input int stall_len, output int cyc);
      int          nwr;
      int          left;
      logic        ok;
      logic [32:0] snap;
      nwr  = 0;
      left = stall_len;
      ok   = 1'b1;
      snap = '0;
      @(negedge clk);
      start[u] = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start[u] = 1'b0;
      check("busy_on", busy[u], 1);
      while (!over_flag[u] && cyc < 5000) begin
         if (wr_en[u] && nwr == stall_at && left > 0) begin
            wr_ready[u] = 1'b0;
            if (left == stall_len) snap = {wr_en[u], wr_addr[u], wr_data[u]};
            else if ({wr_en[u], wr_addr[u], wr_data[u]} !== snap) ok = 1'b0;
            if (rd_en[u]) ok = 1'b0;
            left--;
         end else begin
            wr_ready[u] = 1'b1;
            if (wr_en[u]) nwr++;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      wr_ready[u] = 1'b1;
      if (stall_len > 0) begin
         check("stall_stable", ok, 1);
         check("stall_used", left, 0);
      end
   endtask

   task automatic push_b_writes();
      int exp_b [8];
      exp_b = '{5, 7, 13, 15, 21, 23, 29, 31};
      for (int k = 0; k < 8; k++) exp_q.push_back({2'd1, 16'(k), 16'(exp_b[k])});
   endtask

   initial begin
      int cyc;
      int idx;
      checks   = 0;
      errors   = 0;
      rd_cnt2  = 0;
      bad_rd2  = 0;
      chk_rd   = 1'b0;
      rst      = 1'b0;
      start    = '0;
      wr_ready = 3'b111;

      vecs[0] = '{a: 3,      b: -7,     c: 9,  d: 2,  exp_max: 9};
      vecs[1] = '{a: -5,     b: -3,     c: -8, d: -3, exp_max: -3};
      vecs[2] = '{a: -32768, b: -32768, c: -32768, d: -32768, exp_max: -32768};
      vecs[3] = '{a: 32767,  b: -32768, c: 0,  d: -1, exp_max: 32767};
      for (int v = 4; v < 8; v++) begin
         vecs[v].a = 16'($urandom_range(0, 65535));
         vecs[v].b = 16'($urandom_range(0, 65535));
         vecs[v].c = 16'($urandom_range(0, 65535));
         vecs[v].d = 16'($urandom_range(0, 65535));
         vecs[v].exp_max = max4(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      end
      for (int k = 0; k < 32; k++) mem1[k] = 16'(k);
      for (int k = 0; k < 25; k++) mem2[k] = 16'($urandom_range(0, 65535));

      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++)
         check("reset_outputs", {over_flag[u], busy[u], rd_en[u], wr_en[u], rd_addr[u], wr_addr[u], wr_data[u]}, 0);
      @(negedge clk);
      rst = 1'b1;

      // table-driven single windows, D=1 H=W=2
      for (int v = 0; v < 8; v++) begin
         mem0[0] = vecs[v].a;
         mem0[1] = vecs[v].b;
         mem0[2] = vecs[v].c;
         mem0[3] = vecs[v].d;
         exp_q.push_back({2'd0, 16'd0, out_of(vecs[v].exp_max)});
         run_pass(0, -1, 0, cyc);
         check("latency_2x2", cyc, 7);
         check("over_flag_2x2", over_flag[0], 1);
         check("busy_off_2x2", busy[0], 0);
         check("drained_2x2", exp_q.size(), 0);
      end

      // D=2 H=W=4 ramp: write data, write order and read order
      push_b_writes();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               idx = c * 16 + 2 * i * 4 + 2 * j;
               rd_q.push_back(16'(idx));
               rd_q.push_back(16'(idx + 1));
               rd_q.push_back(16'(idx + 4));
               rd_q.push_back(16'(idx + 5));
            end
      chk_rd = 1'b1;
      run_pass(1, -1, 0, cyc);
      chk_rd = 1'b0;
      check("latency_4x4", cyc, 49);
      check("reads_drained", rd_q.size(), 0);
      check("drained_4x4", exp_q.size(), 0);

      // 10-cycle back-pressure on the second write
      push_b_writes();
      run_pass(1, 1, 10, cyc);
      check("latency_stall", cyc, 59);
      check("drained_stall", exp_q.size(), 0);

      // restart attempt mid-pass, then asynchronous reset mid-pass
      push_b_writes();
      @(negedge clk);
      start[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[1] = 1'b0;
      repeat (8) @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      check("busy_after_restart", busy[1], 1);
      repeat (5) @(negedge clk);
      check("writes_before_abort", 8 - exp_q.size(), 2);
      #3;
      rst = 1'b0;
      #1;
      check("abort_clears", {busy[1], over_flag[1], rd_en[1], wr_en[1]}, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_after_abort", {busy[1], over_flag[1]}, 0);
      push_b_writes();
      run_pass(1, -1, 0, cyc);
      check("latency_after_abort", cyc, 49);
      check("drained_after_abort", exp_q.size(), 0);

      // odd geometry D=1 H=W=5: last row/column never read
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            idx = 2 * i * 5 + 2 * j;
            exp_q.push_back({2'd2, 16'(i * 2 + j),
                             out_of(max4(mem2[idx], mem2[idx + 1], mem2[idx + 5], mem2[idx + 6]))});
         end
      rd_cnt2 = 0;
      bad_rd2 = 0;
      run_pass(2, -1, 0, cyc);
      check("latency_5x5", cyc, 25);
      check("reads_5x5", rd_cnt2, 16);
      check("edge_reads_5x5", bad_rd2, 0);
      check("drained_5x5", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
